sid_wavetable_arbiter: RTL and testbench

- Time-multiplexes one shared combined-waveform lookup ROM (sid_tables-style: 12-bit sawtooth/triangle in; _st/p_t/ps_/pst bytes out) among NUM_VOICES oscillator voices.
- Each 1 MHz tick, it walks the voices in order: presents each voice's sawtooth/triangle to the ROM, waits the ROM latency, then captures the four result bytes into per-voice holding registers.
- Sits between the sid_voice instances and the table ROM inside a SID top; scales to dual-SID (6 voices) without a second ROM.

---
 rtl/sid_wavetable_arbiter.sv | 153 +++++++++++++++
 tb/tb_sid_wavetable_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sid_wavetable_arbiter.sv
// Shares one combined-waveform ROM among NUM_VOICES voices. On each 1 MHz tick it
// issues every voice's saw/tri address in turn and latches that voice's four result bytes.
module sid_wavetable_arbiter #(
  parameter int NUM_VOICES = 3,
  parameter int ROM_LAT    = 1
) (
  input  logic                    clk32,
  input  logic                    reset,
  input  logic                    ce_1m,
  input  logic                    en,
  input  logic [NUM_VOICES*12-1:0] saw_in,
  input  logic [NUM_VOICES*12-1:0] tri_in,
  output logic [11:0]             rom_sawtooth,
  output logic [11:0]             rom_triangle,
  input  logic [7:0]              rom_st,
  input  logic [7:0]              rom_pt,
  input  logic [7:0]              rom_ps,
  input  logic [7:0]              rom_pst,
  output logic [NUM_VOICES*8-1:0] st_out,
  output logic [NUM_VOICES*8-1:0] pt_out,
  output logic [NUM_VOICES*8-1:0] ps_out,
  output logic [NUM_VOICES*8-1:0] pst_out,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [VW-1:0] LAST_V   = VW'(NUM_VOICES - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'((ROM_LAT > 0) ? ROM_LAT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] v_q, v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   rs_q, rs_d, rt_q, rt_d;
  logic          busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic          cap;
  logic          tick;

  logic [11:0] saw_arr [NUM_VOICES];
  logic [11:0] tri_arr [NUM_VOICES];
  logic [31:0] res_q   [NUM_VOICES];
  logic [31:0] res_d   [NUM_VOICES];

  assign tick = ce_1m & en;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_ISSUE;
          v_d     = '0;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        rs_d = saw_arr[v_q];
        rt_d = tri_arr[v_q];
        if (ROM_LAT == 0) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        cap = 1'b1;
        if (v_q == LAST_V) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_ISSUE;
          v_d     = v_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A tick while busy still lets this cycle's issue/capture land, then restarts from voice 0.
    if (tick && (state_q != S_IDLE)) begin
      state_d = S_ISSUE;
      v_d     = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      ovr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q <= S_IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    assign saw_arr[gi] = saw_in[12*gi +: 12];
    assign tri_arr[gi] = tri_in[12*gi +: 12];

    always_comb begin
      res_d[gi] = res_q[gi];
      if (cap && (v_q == VW'(gi))) res_d[gi] = {rom_st, rom_pt, rom_ps, rom_pst};
    end

    always_ff @(posedge clk32) begin
      if (reset) res_q[gi] <= '0;
      else       res_q[gi] <= res_d[gi];
    end

    assign st_out [8*gi +: 8] = res_q[gi][31:24];
    assign pt_out [8*gi +: 8] = res_q[gi][23:16];
    assign ps_out [8*gi +: 8] = res_q[gi][15:8];
    assign pst_out[8*gi +: 8] = res_q[gi][7:0];
  end

  assign rom_sawtooth = rs_q;
  assign rom_triangle = rt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_sid_wavetable_arbiter.sv
// Bench for sid_wavetable_arbiter: three configurations share one stimulus stream; each is
// checked every cycle against a schedule-based model, plus hand-computed literal checks.
module tb_sid_wavetable_arbiter;

  logic        clk32 = 1'b0;
  logic        reset = 1'b1;
  logic        ce_1m = 1'b0;
  logic        en    = 1'b1;
  logic [95:0] saw_all = '0;
  logic [95:0] tri_all = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk32 = ~clk32;

  // ROM contents: st = saw[11:4], pt = tri[11:4], ps = saw[11:4]+0x40, pst = saw^tri bytes
  function automatic logic [31:0] rom_f(input logic [11:0] s, input logic [11:0] t);
    logic [7:0] a, b;
    a = s[11:4];
    b = t[11:4];
    return {a, b, a + 8'h40, a ^ b};
  endfunction

  task automatic cmp(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %h expected %h at %0t", inst, name, act, exp, $time);
    end
  endtask

  task automatic set_saw(input logic [11:0] off);
    for (int i = 0; i < 8; i++) begin
      saw_all[12*i +: 12] = 12'((i + 1) * 256) + off;
      tri_all[12*i +: 12] = 12'hF00 - 12'(i * 256);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int N    = (gi == 2) ? 6 : 3;
    localparam int L    = (gi == 1) ? 3 : 1;
    localparam int SLOT = L + 2;

    logic [11:0]    rs, rt;
    logic [7:0]     r_st, r_pt, r_ps, r_pst;
    logic [N*8-1:0] st_o, pt_o, ps_o, pst_o;
    logic           busy, done, ovr;
    logic [31:0]    rom_pipe [L];

    sid_wavetable_arbiter #(.NUM_VOICES(N), .ROM_LAT(L)) dut (
      .clk32(clk32), .reset(reset), .ce_1m(ce_1m), .en(en),
      .saw_in(saw_all[N*12-1:0]), .tri_in(tri_all[N*12-1:0]),
      .rom_sawtooth(rs), .rom_triangle(rt),
      .rom_st(r_st), .rom_pt(r_pt), .rom_ps(r_ps), .rom_pst(r_pst),
      .st_out(st_o), .pt_out(pt_o), .ps_out(ps_o), .pst_out(pst_o),
      .busy(busy), .done(done), .overrun(ovr)
    );

    // L-stage registered ROM driven by the DUT's address.
    always_ff @(posedge clk32) begin
      rom_pipe[0] <= rom_f(rs, rt);
      for (int s = 1; s < L; s++) rom_pipe[s] <= rom_pipe[s-1];
    end
    assign {r_st, r_pt, r_ps, r_pst} = rom_pipe[L-1];

    // Model: an accepted tick at edge t0 schedules voice v's address at t0+v*SLOT+1 and its
    // capture at t0+(v+1)*SLOT; the last capture ends the sequence.
    logic [11:0] m_rs, m_rt;
    logic [31:0] m_res [N];
    bit          m_busy, m_done, m_ovr;
    int          m_t0, k;

    initial begin
      m_rs = '0; m_rt = '0; m_busy = 0; m_done = 0; m_ovr = 0; m_t0 = 0; k = 0;
      for (int v = 0; v < N; v++) m_res[v] = '0;
      forever begin
        @(posedge clk32);
        k++;
        if (reset) begin
          m_rs = '0; m_rt = '0; m_busy = 0; m_done = 0; m_ovr = 0;
          for (int v = 0; v < N; v++) m_res[v] = '0;
        end else begin
          automatic bit was = m_busy;
          automatic int rel = k - m_t0;
          m_done = 0;
          if (was && (rel % SLOT == 1)) begin
            m_rs = saw_all[12*(rel/SLOT) +: 12];
            m_rt = tri_all[12*(rel/SLOT) +: 12];
          end
          if (was && (rel % SLOT == 0)) begin
            m_res[rel/SLOT - 1] = rom_f(m_rs, m_rt);
            if (rel / SLOT == N) begin
              m_busy = 0;
              m_done = 1;
            end
          end
          if (ce_1m && en) begin
            if (was) begin
              m_ovr  = 1;
              m_done = 0;
            end
            m_busy = 1;
            m_t0   = k;
          end
        end
      end
    end

    initial begin
      logic [N*8-1:0] e_st, e_pt, e_ps, e_pst;
      @(posedge clk32);
      forever begin
        @(negedge clk32);
        for (int v = 0; v < N; v++) begin
          e_st [8*v +: 8] = m_res[v][31:24];
          e_pt [8*v +: 8] = m_res[v][23:16];
          e_ps [8*v +: 8] = m_res[v][15:8];
          e_pst[8*v +: 8] = m_res[v][7:0];
        end
        cmp(gi, "rom_sawtooth", 64'(rs), 64'(m_rs));
        cmp(gi, "rom_triangle", 64'(rt), 64'(m_rt));
        cmp(gi, "st_out",  64'(st_o),  64'(e_st));
        cmp(gi, "pt_out",  64'(pt_o),  64'(e_pt));
        cmp(gi, "ps_out",  64'(ps_o),  64'(e_ps));
        cmp(gi, "pst_out", 64'(pst_o), 64'(e_pst));
        cmp(gi, "busy",    64'(busy),  64'(m_busy));
        cmp(gi, "done",    64'(done),  64'(m_done));
        cmp(gi, "overrun", 64'(ovr),   64'(m_ovr));
      end
    end
  end

  int  done_at, done_cnt, busy_cnt;
  logic [7:0] b_v0_j4, b_v0_j5;
  bit  zero_at_rst;

  // Tick sampled at edge T0; observation j follows edge T0+j.
  task automatic run(input int n, input int tick2_at, input int rst_at, input int en_drop_at);
    done_at = -1; done_cnt = 0; busy_cnt = 0; zero_at_rst = 0;
    ce_1m = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(negedge clk32);
      if (g_inst[0].done) begin done_cnt++; done_at = j; end
      if (g_inst[0].busy) busy_cnt++;
      if (j == 4) b_v0_j4 = g_inst[1].st_o[7:0];
      if (j == 5) b_v0_j5 = g_inst[1].st_o[7:0];
      if (j == rst_at)
        zero_at_rst = (g_inst[0].rs == 0) && (g_inst[0].rt == 0) && (g_inst[0].st_o == 0) &&
                      (g_inst[0].pst_o == 0) && !g_inst[0].busy && !g_inst[0].done && !g_inst[0].ovr;
      ce_1m = (j + 1 == tick2_at);
      reset = (j + 1 == rst_at);
      if (j + 1 == en_drop_at) en = 1'b0;
    end
    ce_1m = 1'b0; reset = 1'b0; en = 1'b1;
  endtask

  initial begin
    set_saw(12'h000);
    repeat (3) @(negedge clk32);
    cmp(0, "lit_reset_busy", 64'(g_inst[0].busy), 64'd0);
    cmp(0, "lit_reset_addr", 64'(g_inst[0].rs), 64'd0);
    reset = 1'b0;
    @(negedge clk32);

    // Single tick, defaults: captures at T0+3/6/9, done after T0+9.
    run(26, -1, -1, -1);
    cmp(0, "lit_st",       64'(g_inst[0].st_o), 64'h302010);
    cmp(0, "lit_pt",       64'(g_inst[0].pt_o), 64'hD0E0F0);
    cmp(0, "lit_pst",      64'(g_inst[0].pst_o), 64'hE0C0E0);
    cmp(0, "lit_done_at",  64'(done_at), 64'd9);
    cmp(0, "lit_done_cnt", 64'(done_cnt), 64'd1);
    cmp(0, "lit_busy_cnt", 64'(busy_cnt), 64'd9);
    cmp(1, "lit_lat3_v0_before", 64'(b_v0_j4), 64'h00);
    cmp(1, "lit_lat3_v0_at5",    64'(b_v0_j5), 64'h10);
    cmp(2, "lit_six_st",   64'(g_inst[2].st_o), 64'h605040302010);

    // Overrun: second tick at T0+5, restart completes at T0+14.
    set_saw(12'h050);
    run(26, 5, -1, -1);
    cmp(0, "lit_ovr",          64'(g_inst[0].ovr), 64'd1);
    cmp(0, "lit_ovr_done_at",  64'(done_at), 64'd14);
    cmp(0, "lit_ovr_done_cnt", 64'(done_cnt), 64'd1);
    cmp(0, "lit_ovr_st",       64'(g_inst[0].st_o), 64'h352515);

    // en low: tick ignored.
    set_saw(12'h070);
    en = 1'b0; ce_1m = 1'b1;
    @(negedge clk32);
    ce_1m = 1'b0;
    repeat (4) @(negedge clk32);
    cmp(0, "lit_en0_busy", 64'(g_inst[0].busy), 64'd0);
    cmp(0, "lit_en0_addr", 64'(g_inst[0].rs), 64'h350);
    cmp(0, "lit_en0_st",   64'(g_inst[0].st_o), 64'h352515);
    en = 1'b1;

    // en dropped mid-sequence: sequence still completes.
    run(26, -1, -1, 2);
    cmp(0, "lit_endrop_done_at", 64'(done_at), 64'd9);
    cmp(0, "lit_endrop_st",      64'(g_inst[0].st_o), 64'h372717);
    cmp(0, "lit_ovr_sticky",     64'(g_inst[0].ovr), 64'd1);

    // Reset at T0+4, then a clean sequence.
    set_saw(12'h090);
    run(6, -1, 4, -1);
    cmp(0, "lit_rst_zero", 64'(zero_at_rst), 64'd1);
    set_saw(12'h000);
    run(26, -1, -1, -1);
    cmp(0, "lit_post_rst_done_at", 64'(done_at), 64'd9);
    cmp(0, "lit_post_rst_ovr",     64'(g_inst[0].ovr), 64'd0);
    cmp(0, "lit_post_rst_st",      64'(g_inst[0].st_o), 64'h302010);
    cmp(2, "lit_post_rst_six",     64'(g_inst[2].st_o), 64'h605040302010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
